downscale_block_16: RTL
=======================

Name: downscale_block_16

Overview:
Producer end of the downscale→sub_2 interface in the 16-bit softmax compute chain. Buffers one input vector of up to DEPTH signed samples and tracks its maximum. It then streams each sample minus the maximum (always ≤ 0) one per cycle on the downscale data/valid port. It also publishes the element count that the sub_2 stage consumes as its number_of_data input.

Parameters:
data_size, 16, sample width (signed two's complement, fixed-point format untouched)
DEPTH, 10, maximum vector length held in the buffer (1..255)

Ports:
clock_i  in  1  clock, rising edge
reset_n_i  in  1  asynchronous active-low reset
downscale_data_i  in  data_size  input sample, signed
downscale_data_valid_i  in  1  sample strobe
downscale_last_i  in  1  marks final sample of the vector (qualified by valid)
downscale_clear_i  in  1  synchronous abort/rearm pulse
downscale_ready_o  out  1  block accepts samples (IDLE or LOAD)
downscale_data_o  out  data_size  x[k] − max, signed, saturated
downscale_data_valid_o  out  1  output strobe, one per element
downscale_number_of_data_o  out  8  number of elements in current vector
downscale_max_o  out  data_size  vector maximum
downscale_done_o  out  1  all elements emitted; sticky until clear/reset

Behaviour:
- Reset (async, reset_n_i low): state IDLE; all outputs 0, except ready_o = 1. Buffer contents don't-care. Count = 0, max = 0.
- States: IDLE, LOAD, EMIT, DONE. Encoding is 2 bits.
- IDLE: ready_o = 1.
  - Valid sample → store at index 0; max ← sample; count ← 1.
  - If last_i is also high, or DEPTH == 1 → EMIT; else → LOAD.
- LOAD: ready_o = 1.
  - Each valid stores at index count; max ← signed max(max, sample); count ← count + 1.
  - Go to EMIT when the accepted sample has last_i = 1 or count reaches DEPTH. Reaching DEPTH forces the end of the vector.
- Input valid while in EMIT/DONE (ready_o = 0): sample dropped; no state change.
- Timing: final sample accepted at edge T.
  - number_of_data_o and max_o are valid from T+1. Both are held until clear/reset.
  - EMIT begins at T+1; data_valid_o is high for exactly N consecutive cycles starting at T+2 (registered output).
  - Element k is output in cycle T+2+k, in arrival order.
- Arithmetic: diff = sign-extend(x[k]) − sign-extend(max), 17 bits.
  - diff ≤ 0 by construction.
  - If diff < −32768, output 16'h8000 (saturate); else output diff[15:0].
  - Never wraps positive.
- After the last element: → DONE. done_o = 1 from the cycle after the last valid_o, held.
  - data_o returns to 0 whenever valid_o = 0.
- downscale_clear_i: highest priority in every state.
  - Next state IDLE; done_o, valid_o, count, number_of_data_o and max_o cleared next cycle.
  - A sample presented with clear in the same cycle is dropped.
  - Clear mid-EMIT truncates the stream with no further valid_o.
- Reset mid-operation: immediate return to reset values; no partial stream resumes.
- Equal samples: max is unchanged; the corresponding outputs are 0.
- N = 1: a single output of 0.

Decomposition:
- Shared include (softmax_defs): DATA_SIZE = 16, COUNT_W = 8, state localparams IDLE/LOAD/EMIT/DONE, SAT_MIN = 16'h8000.
- Sub-module downscale_max_tracker_16: registered signed running-max with init/update/clear inputs.
- Buffer, counters and FSM stay in the top module.

Test Plan:
- Samples 0x0100, 0x0300, 0x0200 (last on third) → number_of_data_o = 3 and max_o = 0x0300 at T+1; outputs 0xFE00, 0x0000, 0xFF00 at T+2..T+4; done_o = 1 at T+5.
- Single sample 0x8000 with last → one output 0x0000; number_of_data_o = 1.
- Samples 0x7FFF, 0x8000 (last) → outputs 0x0000, 0x8000 (saturated, not 0x0001).
- 12 samples without last, DEPTH = 10 → first 10 accepted, ready_o low from T+1, samples 11–12 dropped; 10 outputs emitted.
- clear_i pulsed during the 2nd output cycle → valid_o low next cycle, state IDLE, done_o stays 0; a new 2-sample vector then processes normally.
- reset_n_i low asynchronously mid-LOAD → all outputs zero immediately (ready_o = 1); a fresh vector after release produces correct results.

Source files
------------

// File: rtl/downscale_block_16_pkg.sv
// downscale_block_16_pkg: shared widths, FSM states and saturation constant for the downscale stage
package downscale_block_16_pkg;
  localparam int DATA_SIZE = 16;
  localparam int COUNT_W = 8;
  localparam logic [DATA_SIZE-1:0] SAT_MIN = 16'h8000;
  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;
endpackage

// File: rtl/downscale_block_16_max_tracker.sv
// downscale_max_tracker_16: registered signed running maximum of the incoming vector
module downscale_max_tracker_16
  import downscale_block_16_pkg::*;
#(
  parameter int data_size = DATA_SIZE
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 init_i,
  input  logic                 update_i,
  input  logic                 clear_i,
  input  logic [data_size-1:0] sample_i,
  output logic [data_size-1:0] max_o
);
  logic [data_size-1:0] max_d, max_q;
  // clear wins, init loads the first sample, update keeps the larger signed value
  always_comb
    max_d = clear_i ? '0 :
            init_i ? sample_i :
            (update_i && $signed(sample_i) > $signed(max_q)) ? sample_i : max_q;
  // running maximum register
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) max_q <= '0;
    else max_q <= max_d;
  assign max_o = max_q;
endmodule

// File: rtl/downscale_block_16.sv
// downscale_block_16: buffers one vector, tracks its max and streams x[k] - max with saturation
module downscale_block_16
  import downscale_block_16_pkg::*;
#(
  parameter int data_size = DATA_SIZE,
  parameter int DEPTH = 10
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic [data_size-1:0] downscale_data_i,
  input  logic                 downscale_data_valid_i,
  input  logic                 downscale_last_i,
  input  logic                 downscale_clear_i,
  output logic                 downscale_ready_o,
  output logic [data_size-1:0] downscale_data_o,
  output logic                 downscale_data_valid_o,
  output logic [COUNT_W-1:0]   downscale_number_of_data_o,
  output logic [data_size-1:0] downscale_max_o,
  output logic                 downscale_done_o
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [COUNT_W-1:0] depth_c = COUNT_W'(DEPTH);
  localparam logic [data_size-1:0] sat_min = {SAT_MIN[DATA_SIZE-1], {(data_size-1){1'b0}}};
  state_t state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d, idx_q, idx_d;
  logic [data_size-1:0] data_q, data_d;
  logic valid_q, valid_d, done_q, done_d;
  logic [data_size-1:0] buf_q [DEPTH];
  logic [data_size-1:0] buf_d [DEPTH];
  logic [data_size-1:0] max_w, cur;
  logic [data_size:0] diff;
  logic ready, accept, sat, init, update;
  assign ready  = (state_q == IDLE) || (state_q == LOAD);
  assign accept = downscale_data_valid_i && ready && !downscale_clear_i;
  assign cur    = buf_q[idx_q[IW-1:0]];
  assign diff   = {cur[data_size-1], cur} - {max_w[data_size-1], max_w};
  assign sat    = diff[data_size] & ~diff[data_size-1];
  downscale_max_tracker_16 #(.data_size(data_size)) u_max (
    .clock_i  (clock_i),
    .reset_n_i(reset_n_i),
    .init_i   (init),
    .update_i (update),
    .clear_i  (downscale_clear_i),
    .sample_i (downscale_data_i),
    .max_o    (max_w)
  );
  // next state: clear aborts anything, otherwise load, emit one element per cycle, then hold done
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    done_d  = done_q;
    valid_d = 1'b0;
    data_d  = '0;
    buf_d   = buf_q;
    init    = 1'b0;
    update  = 1'b0;
    if (downscale_clear_i) begin
      state_d = IDLE;
      count_d = '0;
      idx_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          buf_d[0] = downscale_data_i;
          init     = 1'b1;
          count_d  = COUNT_W'(1);
          idx_d    = '0;
          state_d  = (downscale_last_i || DEPTH == 1) ? EMIT : LOAD;
        end
        LOAD: if (accept) begin
          buf_d[count_q[IW-1:0]] = downscale_data_i;
          update  = 1'b1;
          count_d = count_q + COUNT_W'(1);
          state_d = (downscale_last_i || count_d == depth_c) ? EMIT : LOAD;
        end
        EMIT: begin
          valid_d = 1'b1;
          data_d  = sat ? sat_min : diff[data_size-1:0];
          idx_d   = idx_q + COUNT_W'(1);
          state_d = (idx_q == count_q - COUNT_W'(1)) ? DONE : EMIT;
        end
        default: done_d = 1'b1;
      endcase
    end
  end
  // control and output registers
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  // sample buffer, contents irrelevant after reset
  always_ff @(posedge clock_i)
    buf_q <= buf_d;
  assign downscale_ready_o          = ready;
  assign downscale_data_o           = data_q;
  assign downscale_data_valid_o     = valid_q;
  assign downscale_number_of_data_o = count_q;
  assign downscale_max_o            = max_w;
  assign downscale_done_o           = done_q;
endmodule
